timeset_ctrl: RTL and testbench

Time-set controller for the digital clock. It debounces the two push-buttons and runs the RUN / SET_MIN / SET_HOUR mode machine. It gates the seconds/minutes/hours counter advance enables, with press and auto-repeat increments in set modes. It sits between the 1 s divider and the three mod-60/60/24 counters, and drives the mode and blink inputs of the display block.

---
 rtl/timeset_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_timeset_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timeset_ctrl.sv
// Time-set controller: debounces the mode/add buttons, runs the RUN/SET_MIN/SET_HOUR
// mode machine and gates the counter advance, clear and blink signals for the clock.
module timeset_ctrl #(
    parameter int DB_CYCLES    = 1000000,
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 10000000,
    parameter int TIMEOUT_S    = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button0,
    input  logic       button1,
    input  logic       clk_1s_tick,
    input  logic       carry_m,
    input  logic       carry_h,
    output logic       sec_en,
    output logic       inc_m,
    output logic       inc_h,
    output logic       clr_s,
    output logic [1:0] mod,
    output logic       blink
);

    localparam int DB_W  = $clog2(DB_CYCLES + 1);
    localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
    localparam int TMO_W = $clog2(TIMEOUT_S + 1);

    // After each repeat the counter reloads so the next fire lands REPEAT_RATE cycles later.
    localparam logic [RPT_W-1:0] RPT_FIRE   = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_RATE + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_MIN  = 2'b01,
        ST_SET_HOUR = 2'b10
    } state_t;

    logic [1:0] btn_raw;
    logic [1:0] btn_level;
    logic [1:0] btn_press;

    assign btn_raw = {button1, button0};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic            sync1_q, sync1_d;
            logic            sync2_q, sync2_d;
            logic            db_q, db_d;
            logic            db_prev_q, db_prev_d;
            logic [DB_W-1:0] cnt_q, cnt_d;

            always_comb begin
                sync1_d   = btn_raw[gi];
                sync2_d   = sync1_q;
                db_prev_d = db_q;
                db_d      = db_q;
                cnt_d     = '0;
                if (sync2_q != db_q) begin
                    if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
                        db_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + DB_W'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    sync1_q   <= 1'b0;
                    sync2_q   <= 1'b0;
                    db_q      <= 1'b0;
                    db_prev_q <= 1'b0;
                    cnt_q     <= '0;
                end else begin
                    sync1_q   <= sync1_d;
                    sync2_q   <= sync2_d;
                    db_q      <= db_d;
                    db_prev_q <= db_prev_d;
                    cnt_q     <= cnt_d;
                end
            end

            assign btn_level[gi] = db_q;
            assign btn_press[gi] = db_q & ~db_prev_q;
        end
    endgenerate

    state_t             state_q, state_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [RPT_W-1:0]   rpt_cnt_q, rpt_cnt_d;
    logic               sec_en_q, sec_en_d;
    logic               inc_m_q, inc_m_d;
    logic               inc_h_q, inc_h_d;
    logic               clr_s_q, clr_s_d;
    logic               blink_q, blink_d;

    logic in_set;
    logic any_press;
    logic tmo_evt;
    logic rpt_evt;
    logic state_chg;
    logic add_evt;

    always_comb begin
        in_set    = (state_q != ST_RUN);
        any_press = |btn_press;
        // A press in the terminal-count cycle restarts the timer instead of timing out.
        tmo_evt   = in_set && clk_1s_tick && (tmo_cnt_q == TMO_W'(TIMEOUT_S - 1)) && !any_press;
        rpt_evt   = in_set && btn_level[1] && (rpt_cnt_q == RPT_FIRE);

        state_d = state_q;
        if (btn_press[0]) begin
            case (state_q)
                ST_RUN:     state_d = ST_SET_MIN;
                ST_SET_MIN: state_d = ST_SET_HOUR;
                default:    state_d = ST_RUN;
            endcase
        end else if (tmo_evt) begin
            state_d = ST_RUN;
        end
        state_chg = (state_d != state_q);

        // Any mode change swallows a coinciding add, whether press or repeat.
        add_evt = in_set && (btn_press[1] || rpt_evt) && !state_chg;

        tmo_cnt_d = tmo_cnt_q;
        if (!in_set || state_chg || any_press) begin
            tmo_cnt_d = '0;
        end else if (clk_1s_tick) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end

        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
        if (!in_set || state_chg || !btn_level[1]) begin
            rpt_cnt_d = '0;
        end else if (rpt_cnt_q == RPT_FIRE) begin
            rpt_cnt_d = RPT_RELOAD;
        end

        sec_en_d = (state_d == ST_RUN);
        inc_m_d  = (state_q == ST_RUN) ? carry_m : ((state_q == ST_SET_MIN) && add_evt);
        inc_h_d  = (state_q == ST_RUN) ? carry_h : ((state_q == ST_SET_HOUR) && add_evt);
        clr_s_d  = in_set && (state_d == ST_RUN);

        blink_d = blink_q;
        if (state_d == ST_RUN) begin
            blink_d = 1'b0;
        end else if (state_chg) begin
            blink_d = 1'b1;
        end else if (clk_1s_tick) begin
            blink_d = ~blink_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            tmo_cnt_q <= '0;
            rpt_cnt_q <= '0;
            sec_en_q  <= 1'b1;
            inc_m_q   <= 1'b0;
            inc_h_q   <= 1'b0;
            clr_s_q   <= 1'b0;
            blink_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            rpt_cnt_q <= rpt_cnt_d;
            sec_en_q  <= sec_en_d;
            inc_m_q   <= inc_m_d;
            inc_h_q   <= inc_h_d;
            clr_s_q   <= clr_s_d;
            blink_q   <= blink_d;
        end
    end

    assign mod    = state_q;
    assign sec_en = sec_en_q;
    assign inc_m  = inc_m_q;
    assign inc_h  = inc_h_q;
    assign clr_s  = clr_s_q;
    assign blink  = blink_q;

endmodule

// File: tb/tb_timeset_ctrl.sv
// Bench for timeset_ctrl: directed scenarios with fixed expectations plus a randomized
// run, all compared against a rule-level reference model of the controller.
module tb_timeset_ctrl;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 5;
    localparam int TO = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       button0 = 1'b0;
    logic       button1 = 1'b0;
    logic       clk_1s_tick = 1'b0;
    logic       carry_m = 1'b0;
    logic       carry_h = 1'b0;
    logic       sec_en, inc_m, inc_h, clr_s, blink;
    logic [1:0] mod;

    int n_checks = 0;
    int n_errors = 0;

    timeset_ctrl #(
        .DB_CYCLES   (DB),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE (RR),
        .TIMEOUT_S   (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .button0    (button0),
        .button1    (button1),
        .clk_1s_tick(clk_1s_tick),
        .carry_m    (carry_m),
        .carry_h    (carry_h),
        .sec_en     (sec_en),
        .inc_m      (inc_m),
        .inc_h      (inc_h),
        .clr_s      (clr_s),
        .mod        (mod),
        .blink      (blink)
    );

    always #5 clk = ~clk;

    // Reference model: debounced level from a raw-sample history, repeat timing from the
    // cycle the hold started, timeout from a tick count since the last press or entry.
    int          cyc = 0;
    int          m_anchor = 0;
    int          m_tcount = 0;
    logic [1:0]  m_mode = 2'd0;
    logic [1:0]  m_db = 2'b00;
    logic [1:0]  m_press = 2'b00;
    logic [DB+1:0] m_hist0 = '0;
    logic [DB+1:0] m_hist1 = '0;
    logic        exp_sec = 1'b1, exp_inc_m = 1'b0, exp_inc_h = 1'b0, exp_clr = 1'b0, m_blink = 1'b0;

    logic [DB+1:0] nh0, nh1;
    logic [DB-1:0] w0, w1;
    logic [1:0]  n_db, n_press, n_mode;
    logic        inset, p_any, tmo, rpt, chg, add;
    int          age, n_anchor, n_tcount;
    logic        n_sec, n_inc_m, n_inc_h, n_clr, n_blink;

    always_comb begin
        nh0 = {m_hist0[DB:0], button0};
        nh1 = {m_hist1[DB:0], button1};
        w0  = nh0[DB+1:2];
        w1  = nh1[DB+1:2];
        n_db = m_db;
        if (m_db[0] ? (w0 == '0) : (w0 == '1)) n_db[0] = ~m_db[0];
        if (m_db[1] ? (w1 == '0) : (w1 == '1)) n_db[1] = ~m_db[1];
        n_press = n_db & ~m_db;

        inset = (m_mode != 2'd0);
        p_any = m_press[0] | m_press[1];
        tmo   = inset && clk_1s_tick && (m_tcount == TO - 1) && !p_any;
        age   = cyc - m_anchor;
        rpt   = inset && m_db[1] && (age >= RD) && (((age - RD) % RR) == 0);
        if (m_press[0]) n_mode = 2'((int'(m_mode) + 1) % 3);
        else if (tmo)   n_mode = 2'd0;
        else            n_mode = m_mode;
        chg = (n_mode != m_mode);
        add = inset && (m_press[1] || rpt) && !chg;

        n_anchor = (!inset || chg || !m_db[1]) ? cyc + 1 : m_anchor;
        if (!inset || chg || p_any) n_tcount = 0;
        else if (clk_1s_tick)       n_tcount = m_tcount + 1;
        else                        n_tcount = m_tcount;

        n_sec   = (n_mode == 2'd0);
        n_inc_m = (m_mode == 2'd0) ? carry_m : ((m_mode == 2'd1) && add);
        n_inc_h = (m_mode == 2'd0) ? carry_h : ((m_mode == 2'd2) && add);
        n_clr   = inset && (n_mode == 2'd0);
        if (n_mode == 2'd0)   n_blink = 1'b0;
        else if (chg)         n_blink = 1'b1;
        else if (clk_1s_tick) n_blink = ~m_blink;
        else                  n_blink = m_blink;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset) begin
            m_hist0 <= '0; m_hist1 <= '0; m_db <= 2'b00; m_press <= 2'b00;
            m_mode <= 2'd0; m_tcount <= 0; m_anchor <= cyc + 1;
            exp_sec <= 1'b1; exp_inc_m <= 1'b0; exp_inc_h <= 1'b0; exp_clr <= 1'b0; m_blink <= 1'b0;
        end else begin
            m_hist0 <= nh0; m_hist1 <= nh1; m_db <= n_db; m_press <= n_press;
            m_mode <= n_mode; m_tcount <= n_tcount; m_anchor <= n_anchor;
            exp_sec <= n_sec; exp_inc_m <= n_inc_m; exp_inc_h <= n_inc_h; exp_clr <= n_clr;
            m_blink <= n_blink;
        end
    end

    logic [6:0] obs, expv;
    assign obs  = {mod, sec_en, inc_m, inc_h, clr_s, blink};
    assign expv = {m_mode, exp_sec, exp_inc_m, exp_inc_h, exp_clr, m_blink};

    // Stimulus only: hold a raw button, release it and let the debouncer settle.
    task automatic press_button(input int b, input int hold);
        if (b == 0) button0 = 1'b1; else button1 = 1'b1;
        repeat (hold) @(negedge clk);
        if (b == 0) button0 = 1'b0; else button1 = 1'b0;
        repeat (DB + 4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs !== 7'b00_1_0000) begin
            n_errors++;
            $display("FAIL reset_values: got %b expected %b", obs, 7'b00_1_0000);
        end
        reset = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL reset_idle: got %b expected %b", obs, expv);
        end
        $display("test_reset done");
    endtask

    task automatic test_bounce();
        int changes = 0;
        logic [1:0] last_mod = mod;
        for (int i = 0; i < 20; i++) begin
            button0 = ((i / 2) % 2 == 0);
            @(negedge clk);
            n_checks++;
            if (mod !== 2'd0 || obs !== expv) begin
                n_errors++;
                $display("FAIL bounce_hold_mode: got %b expected %b", obs, expv);
            end
            if (mod !== last_mod) changes++;
            last_mod = mod;
        end
        button0 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            n_checks++;
            if (mod !== ((i >= 7) ? 2'd1 : 2'd0) || obs !== expv) begin
                n_errors++;
                $display("FAIL bounce_latency i=%0d: got mod=%0d expected %0d (obs %b model %b)",
                         i, mod, (i >= 7) ? 1 : 0, obs, expv);
            end
            if (mod !== last_mod) changes++;
            last_mod = mod;
        end
        button0 = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (changes != 1 || mod !== 2'd1) begin
            n_errors++;
            $display("FAIL bounce_single_change: got %0d changes mod=%0d expected 1 change mod=1",
                     changes, mod);
        end
        $display("test_bounce done");
    endtask

    task automatic test_run_carries();
        press_button(0, 8);
        press_button(0, 8);
        n_checks++;
        if (mod !== 2'd0 || sec_en !== 1'b1) begin
            n_errors++;
            $display("FAIL run_entry: got mod=%0d sec_en=%b expected 0/1", mod, sec_en);
        end
        carry_m = 1'b1;
        @(negedge clk);
        carry_m = 1'b0;
        n_checks++;
        if (inc_m !== 1'b1 || inc_h !== 1'b0) begin
            n_errors++;
            $display("FAIL run_carry_m: got inc_m=%b inc_h=%b expected 1/0", inc_m, inc_h);
        end
        @(negedge clk);
        carry_h = 1'b1;
        n_checks++;
        if (inc_m !== 1'b0) begin
            n_errors++;
            $display("FAIL run_carry_m_width: got inc_m=%b expected 0", inc_m);
        end
        @(negedge clk);
        carry_h = 1'b0;
        n_checks++;
        if (inc_h !== 1'b1 || inc_m !== 1'b0) begin
            n_errors++;
            $display("FAIL run_carry_h: got inc_h=%b inc_m=%b expected 1/0", inc_h, inc_m);
        end
        button1 = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (inc_m !== 1'b0 || inc_h !== 1'b0 || mod !== 2'd0 || sec_en !== 1'b1 || obs !== expv) begin
                n_errors++;
                $display("FAIL run_add_ignored i=%0d: got %b expected %b", i, obs, expv);
            end
            if (i == 10) button1 = 1'b0;
        end
        $display("test_run_carries done");
    endtask

    task automatic test_repeat();
        int pulses = 0;
        logic exp_p;
        press_button(0, 8);
        n_checks++;
        if (mod !== 2'd1 || sec_en !== 1'b0) begin
            n_errors++;
            $display("FAIL repeat_entry: got mod=%0d sec_en=%b expected 1/0", mod, sec_en);
        end
        button1 = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            exp_p = (i == 7) || (i >= 27 && i <= 62 && ((i - 27) % RR) == 0);
            n_checks++;
            if (inc_m !== exp_p || inc_h !== 1'b0 || sec_en !== 1'b0 || obs !== expv) begin
                n_errors++;
                $display("FAIL repeat_pulse i=%0d: got inc_m=%b expected %b (obs %b model %b)",
                         i, inc_m, exp_p, obs, expv);
            end
            if (inc_m === 1'b1) pulses++;
            if (i == 30) carry_m = 1'b1;
            if (i == 31) carry_m = 1'b0;
            if (i == 58) button1 = 1'b0;
        end
        n_checks++;
        if (pulses != 9) begin
            n_errors++;
            $display("FAIL repeat_count: got %0d pulses expected 9", pulses);
        end
        $display("test_repeat done");
    endtask

    task automatic test_timeout();
        press_button(0, 8);
        n_checks++;
        if (mod !== 2'd2 || blink !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_entry: got mod=%0d blink=%b expected 2/1", mod, blink);
        end
        for (int t = 0; t < 3; t++) begin
            repeat (3) @(negedge clk);
            clk_1s_tick = 1'b1;
            @(negedge clk);
            clk_1s_tick = 1'b0;
            n_checks++;
            if (t < 2) begin
                if (mod !== 2'd2 || clr_s !== 1'b0 || blink !== ((t == 0) ? 1'b0 : 1'b1) || obs !== expv) begin
                    n_errors++;
                    $display("FAIL timeout_tick%0d: got %b expected %b", t, obs, expv);
                end
            end else begin
                if (obs !== 7'b00_1_0010 || obs !== expv) begin
                    n_errors++;
                    $display("FAIL timeout_fire: got %b expected %b", obs, 7'b00_1_0010);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (clr_s !== 1'b0 || mod !== 2'd0 || blink !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_clr_width: got clr_s=%b mod=%0d blink=%b expected 0/0/0",
                     clr_s, mod, blink);
        end
        $display("test_timeout done");
    endtask

    task automatic test_simul();
        press_button(0, 8);
        button0 = 1'b1;
        button1 = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            n_checks++;
            if (inc_m !== 1'b0 || inc_h !== 1'b0 || mod !== ((i >= 7) ? 2'd2 : 2'd1) || obs !== expv) begin
                n_errors++;
                $display("FAIL simul_press i=%0d: got %b expected %b", i, obs, expv);
            end
            if (i == 8) begin
                button0 = 1'b0;
                button1 = 1'b0;
            end
        end
        $display("test_simul done");
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        press_button(0, 8);
        press_button(0, 8);
        button1 = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (inc_m === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 2 || mod !== 2'd1) begin
            n_errors++;
            $display("FAIL reset_mid_setup: got %0d pulses mod=%0d expected 2/1", pulses, mod);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        n_checks++;
        if (obs !== 7'b00_1_0000 || obs !== expv) begin
            n_errors++;
            $display("FAIL reset_mid_values: got %b expected %b", obs, 7'b00_1_0000);
        end
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            n_checks++;
            if (inc_m !== 1'b0 || inc_h !== 1'b0 || clr_s !== 1'b0 || mod !== 2'd0 || obs !== expv) begin
                n_errors++;
                $display("FAIL reset_mid_quiet i=%0d: got %b expected %b", i, obs, expv);
            end
            if (i == 20) button1 = 1'b0;
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== expv) begin
                n_errors++;
                bad++;
                if (bad <= 20) $display("FAIL random cycle %0d: got %b expected %b", i, obs, expv);
            end
            if ($urandom_range(0, 11) == 0) button0 = ~button0;
            if ($urandom_range(0, 29) == 0) button1 = ~button1;
            clk_1s_tick = ($urandom_range(0, 7) == 0);
            carry_m     = ($urandom_range(0, 9) == 0);
            carry_h     = ($urandom_range(0, 9) == 0);
            reset       = ($urandom_range(0, 599) != 0);
        end
        reset = 1'b1;
        button0 = 1'b0; button1 = 1'b0;
        clk_1s_tick = 1'b0; carry_m = 1'b0; carry_h = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_bounce();
        test_run_carries();
        test_repeat();
        test_timeout();
        test_simul();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
